// File: rtl/ccsds123b2_selftest_pkg.sv
// Shared types, default widths and helpers for the CCSDS-123 self-test checkers.
package ccsds123b2_selftest_pkg;

  localparam int unsigned DEFAULT_DATA_W = 64;
  localparam int unsigned DEFAULT_CNT_W  = 32;
  localparam int unsigned SAT_MAX_W      = 64;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DONE = 2'd1,
    TOUT = 2'd2
  } checker_state_t;

  // Increment that sticks at the all-ones value of a 'width'-bit counter.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] count,
                                                   input int unsigned           width);
    logic [SAT_MAX_W-1:0] max_v;
    max_v = (width >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
    return (count >= max_v) ? count : count + SAT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/axis_join2.sv
// Two-input AXI-Stream join: both sides are consumed together or not at all.
module axis_join2 (
  input  logic en_i,
  input  logic a_valid_i,
  input  logic b_valid_i,
  output logic a_ready_c,
  output logic b_ready_c,
  output logic fire_c
);

  // Readys depend only on the valids, never on data.
  always_comb begin
    fire_c    = en_i & a_valid_i & b_valid_i;
    a_ready_c = fire_c;
    b_ready_c = fire_c;
  end

endmodule

// File: rtl/axis_golden_checker.sv
// Beat-by-beat comparison of the core output stream against a golden stream,
// with mismatch statistics, length checking and a stall watchdog.
module axis_golden_checker
  import ccsds123b2_selftest_pkg::*;
#(
  parameter int unsigned DATA_W         = DEFAULT_DATA_W,
  parameter int unsigned EXPECTED_BEATS = 4881,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W,
  parameter int unsigned TIMEOUT_CYC    = 1000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dut_data,
  input  logic              dut_valid,
  input  logic              dut_last,
  output logic              dut_ready,
  input  logic [DATA_W-1:0] gold_data,
  input  logic              gold_valid,
  output logic              gold_ready,
  output logic              finished,
  output logic              failed,
  output logic              timed_out,
  output logic              length_err,
  output logic [CNT_W-1:0]  beat_count,
  output logic [CNT_W-1:0]  mismatch_count,
  output logic [CNT_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_dut,
  output logic [DATA_W-1:0] first_err_gold
);

  localparam logic [CNT_W-1:0] LAST_IDX    = CNT_W'(EXPECTED_BEATS - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYC);
  localparam bit               WDOG_EN     = (TIMEOUT_CYC != 0);

  checker_state_t    state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  mism_q, mism_d;
  logic [CNT_W-1:0]  idle_q, idle_d;
  logic [CNT_W-1:0]  first_idx_q, first_idx_d;
  logic [DATA_W-1:0] first_dut_q, first_dut_d;
  logic [DATA_W-1:0] first_gold_q, first_gold_d;
  logic              len_err_q, len_err_d;
  logic              tout_q, tout_d;
  logic              failed_q, failed_d;
  logic              finished_q, finished_d;

  logic in_run_c;
  logic join_fire_c;
  logic join_dut_ready_c;
  logic join_gold_ready_c;

  // Readys are held low while reset is asserted.
  assign in_run_c = rst & (state_q == RUN);

  axis_join2 u_join (
    .en_i      (in_run_c),
    .a_valid_i (dut_valid),
    .b_valid_i (gold_valid),
    .a_ready_c (join_dut_ready_c),
    .b_ready_c (join_gold_ready_c),
    .fire_c    (join_fire_c)
  );

  // After the check ends the core is drained so it never stalls forever.
  assign dut_ready  = join_dut_ready_c | (rst & (state_q != RUN));
  assign gold_ready = join_gold_ready_c;

  // Next-state, counters and first-error capture.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    mism_d       = mism_q;
    idle_d       = idle_q;
    first_idx_d  = first_idx_q;
    first_dut_d  = first_dut_q;
    first_gold_d = first_gold_q;
    len_err_d    = len_err_q;
    tout_d       = tout_q;

    case (state_q)
      RUN: begin
        if (join_fire_c) begin
          beat_d = beat_q + CNT_W'(1);
          idle_d = '0;
          if (dut_data != gold_data) begin
            mism_d = CNT_W'(sat_inc(SAT_MAX_W'(mism_q), CNT_W));
            if (mism_q == '0) begin
              first_idx_d  = beat_q;
              first_dut_d  = dut_data;
              first_gold_d = gold_data;
            end
          end
          if (dut_last) begin
            if (beat_q != LAST_IDX) len_err_d = 1'b1;
            state_d = DONE;
          end else if (beat_q == LAST_IDX) begin
            len_err_d = 1'b1;
            state_d   = DONE;
          end
        end else if (WDOG_EN) begin
          idle_d = idle_q + CNT_W'(1);
          if (idle_d == TIMEOUT_LIM) begin
            tout_d  = 1'b1;
            state_d = TOUT;
          end
        end
      end
      DONE: begin
        if (dut_valid) len_err_d = 1'b1;
      end
      TOUT: begin
      end
      default: state_d = RUN;
    endcase

    failed_d   = (mism_d != '0) | len_err_d | tout_d;
    finished_d = (state_d != RUN);
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      beat_q       <= '0;
      mism_q       <= '0;
      idle_q       <= '0;
      first_idx_q  <= '0;
      first_dut_q  <= '0;
      first_gold_q <= '0;
      len_err_q    <= 1'b0;
      tout_q       <= 1'b0;
      failed_q     <= 1'b0;
      finished_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      mism_q       <= mism_d;
      idle_q       <= idle_d;
      first_idx_q  <= first_idx_d;
      first_dut_q  <= first_dut_d;
      first_gold_q <= first_gold_d;
      len_err_q    <= len_err_d;
      tout_q       <= tout_d;
      failed_q     <= failed_d;
      finished_q   <= finished_d;
    end
  end

  assign finished       = finished_q;
  assign failed         = failed_q;
  assign timed_out      = tout_q;
  assign length_err     = len_err_q;
  assign beat_count     = beat_q;
  assign mismatch_count = mism_q;
  assign first_err_idx  = first_idx_q;
  assign first_err_dut  = first_dut_q;
  assign first_err_gold = first_gold_q;

endmodule

// File: tb/tb_axis_golden_checker.sv
// Randomized self-checking bench for axis_golden_checker against a transaction-level model.
module tb_axis_golden_checker;

  localparam int unsigned DW  = 64;
  localparam int unsigned CW  = 32;
  localparam int unsigned EXP = 8;
  localparam int unsigned TO  = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] dut_data, gold_data;
  logic          dut_valid, dut_last, gold_valid;
  logic          dut_ready, gold_ready;
  logic          finished, failed, timed_out, length_err;
  logic [CW-1:0] beat_count, mismatch_count, first_err_idx;
  logic [DW-1:0] first_err_dut, first_err_gold;

  axis_golden_checker #(
    .DATA_W(DW), .EXPECTED_BEATS(EXP), .CNT_W(CW), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .dut_data(dut_data), .dut_valid(dut_valid), .dut_last(dut_last), .dut_ready(dut_ready),
    .gold_data(gold_data), .gold_valid(gold_valid), .gold_ready(gold_ready),
    .finished(finished), .failed(failed), .timed_out(timed_out), .length_err(length_err),
    .beat_count(beat_count), .mismatch_count(mismatch_count), .first_err_idx(first_err_idx),
    .first_err_dut(first_err_dut), .first_err_gold(first_err_gold)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference model: the list of joined beats summarised by the stream rules.
  int unsigned   m_beats, m_mism, m_first_idx, n_edge, m_last_acc;
  logic [DW-1:0] m_first_dut, m_first_gold;
  bit            m_len, m_tout, m_fin;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_beats = 0; m_mism = 0; m_first_idx = 0; n_edge = 0; m_last_acc = 0;
    m_first_dut = '0; m_first_gold = '0;
    m_len = 0; m_tout = 0; m_fin = 0;
  endtask

  task automatic check_outputs(input string pfx);
    check_eq({pfx, "_finished"},   64'(finished),       64'(m_fin));
    check_eq({pfx, "_failed"},     64'(failed),         64'((m_mism != 0) || m_len || m_tout));
    check_eq({pfx, "_timed_out"},  64'(timed_out),      64'(m_tout));
    check_eq({pfx, "_length_err"}, 64'(length_err),     64'(m_len));
    check_eq({pfx, "_beats"},      64'(beat_count),     64'(m_beats));
    check_eq({pfx, "_mism"},       64'(mismatch_count), 64'(m_mism));
    check_eq({pfx, "_first_idx"},  64'(first_err_idx),  64'(m_first_idx));
    check_eq({pfx, "_first_dut"},  first_err_dut,       m_first_dut);
    check_eq({pfx, "_first_gold"}, first_err_gold,      m_first_gold);
  endtask

  // One clock cycle: drive, check readys, advance, update model, check registered outputs.
  task automatic step(input logic dv, input logic gv, input logic [DW-1:0] dd,
                      input logic [DW-1:0] gd, input logic dl);
    int unsigned idx;
    dut_valid = dv; gold_valid = gv; dut_data = dd; gold_data = gd; dut_last = dl;
    #1;
    check_eq("dut_ready",  64'(dut_ready),  64'(m_fin ? 1'b1 : (dv & gv)));
    check_eq("gold_ready", 64'(gold_ready), 64'(m_fin ? 1'b0 : (dv & gv)));
    @(posedge clk); #1;
    n_edge++;
    if (!m_fin && dv && gv) begin
      idx = m_beats;
      m_beats++;
      m_last_acc = n_edge;
      if (dd != gd) begin
        if (m_mism == 0) begin
          m_first_idx = idx; m_first_dut = dd; m_first_gold = gd;
        end
        m_mism++;
      end
      if (dl) begin
        if (idx != EXP - 1) m_len = 1;
        m_fin = 1;
      end else if (idx == EXP - 1) begin
        m_len = 1;
        m_fin = 1;
      end
    end else if (!m_fin) begin
      if (n_edge - m_last_acc == TO) begin
        m_tout = 1; m_fin = 1;
      end
    end else if (!m_tout && dv) begin
      m_len = 1;
    end
    check_outputs("cyc");
  endtask

  // Asynchronous reset pulse, valids held high to show readys are gated.
  task automatic do_reset();
    rst = 1'b0; dut_valid = 1'b1; gold_valid = 1'b1;
    dut_data = {$urandom, $urandom}; gold_data = {$urandom, $urandom}; dut_last = 1'b0;
    #1;
    model_reset();
    check_outputs("rst");
    check_eq("rst_dut_ready",  64'(dut_ready),  64'(0));
    check_eq("rst_gold_ready", 64'(gold_ready), 64'(0));
    @(posedge clk); #1;
    check_eq("rst_beats_held", 64'(beat_count), 64'(0));
    check_eq("rst_ready_held", 64'(dut_ready),  64'(0));
    rst = 1'b1; dut_valid = 1'b0; gold_valid = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] gd, dd;
    int unsigned   last_at, budget;

    rst = 1'b0; dut_valid = 0; gold_valid = 0; dut_last = 0; dut_data = '0; gold_data = '0;
    model_reset();

    // Identical 8-beat stream.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 1, DW'(i), DW'(i), i == 7);
    check_eq("ident_finished", 64'(finished),       64'(1));
    check_eq("ident_failed",   64'(failed),         64'(0));
    check_eq("ident_beats",    64'(beat_count),     64'(8));
    check_eq("ident_mism",     64'(mismatch_count), 64'(0));

    // Mismatches on beats 3 and 5.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      gd = DW'(i); dd = DW'(i);
      if (i == 3) begin gd = 64'hAA; dd = 64'hAB; end
      if (i == 5) dd = dd ^ 64'h100;
      step(1, 1, dd, gd, i == 7);
    end
    check_eq("mm_count",  64'(mismatch_count), 64'(2));
    check_eq("mm_idx",    64'(first_err_idx),  64'(3));
    check_eq("mm_dut",    first_err_dut,       64'hAB);
    check_eq("mm_gold",   first_err_gold,      64'hAA);
    check_eq("mm_failed", 64'(failed),         64'(1));

    // Early last on beat 5, then drained DUT beats.
    do_reset();
    for (int i = 0; i < 6; i++) step(1, 1, DW'(i), DW'(i), i == 5);
    check_eq("short_len", 64'(length_err), 64'(1));
    check_eq("short_fin", 64'(finished),   64'(1));
    for (int i = 0; i < 3; i++) begin
      step(1, 0, DW'(i), '0, 1'b0);
      check_eq("short_beats_frozen", 64'(beat_count), 64'(6));
    end

    // No last after 8 beats: overrun, 9th beat absorbed.
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 1, DW'(i), DW'(i), 1'b0);
    check_eq("over_len", 64'(length_err), 64'(1));
    check_eq("over_fin", 64'(finished),   64'(1));
    step(1, 1, 64'd8, 64'd8, 1'b1);
    check_eq("over_beats", 64'(beat_count), 64'(8));
    check_eq("over_gold_ready_low", 64'(gold_ready), 64'(0));

    // Watchdog: golden side stalls after two beats.
    do_reset();
    for (int i = 0; i < 2; i++) step(1, 1, DW'(i), DW'(i), 1'b0);
    for (int k = 1; k <= 20; k++) begin
      step(1, 0, 64'd2, '0, 1'b0);
      if (k == 19) check_eq("tout_not_yet", 64'(timed_out), 64'(0));
    end
    check_eq("tout_fired",  64'(timed_out), 64'(1));
    check_eq("tout_failed", 64'(failed),    64'(1));
    check_eq("tout_fin",    64'(finished),  64'(1));

    // Random valid toggling; round 0 takes a mid-stream reset, round 1 is clean.
    for (int r = 0; r < 5; r++) begin
      do_reset();
      last_at = (r <= 1) ? 7 : $urandom_range(4, 10);
      budget  = 0;
      while (!m_fin && budget < 300) begin
        if (r == 0 && budget == 6) do_reset();
        gd = DW'(m_beats) ^ {$urandom, $urandom} & 64'hFFFF_0000_0000_0000;
        dd = gd;
        if (r >= 2 && $urandom_range(0, 5) == 0) dd = dd ^ DW'($urandom_range(1, 255));
        step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, dd, gd, m_beats == last_at);
        budget++;
      end
      check_eq("rand_finished", 64'(finished), 64'(1));
      if (r <= 1) check_eq("rand_clean_failed", 64'(failed), 64'(0));
      for (int i = 0; i < 3; i++) step($urandom_range(0, 1) == 1, 1, '0, '0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/axis_golden_checker.md
Name: axis_golden_checker

Overview:
- Downstream consumer of the ccsds_123b2_core compressed output stream in on-chip self-test builds.
- Joins the core output AXI-Stream with a golden-reference stream (ROM FIFO), compares beat by beat, and reports pass/fail, mismatch statistics, length errors and stall timeouts.
- Replaces ad-hoc compare logic in self-test tops.
- Output registers are read by LEDs or an ILA.

Parameters:
- DATA_W, 64, width of compared data beats.
- EXPECTED_BEATS, 4881, number of beats in a correct stream, including the last-flagged beat.
- CNT_W, 32, width of the beat, mismatch and timeout counters.
- TIMEOUT_CYC, 1000000, consecutive cycles with no accepted beat in RUN before a timeout is declared; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- dut_data  in  DATA_W  core output data.
- dut_valid  in  1  core output valid.
- dut_last  in  1  core output last.
- dut_ready  out  1  ready to the core.
- gold_data  in  DATA_W  golden data.
- gold_valid  in  1  golden valid.
- gold_ready  out  1  ready to the golden source.
- finished  out  1  check complete (DONE or TOUT).
- failed  out  1  any mismatch, length error or timeout.
- timed_out  out  1  watchdog fired.
- length_err  out  1  stream length differs from EXPECTED_BEATS.
- beat_count  out  CNT_W  beats compared in RUN.
- mismatch_count  out  CNT_W  mismatching beats; saturates at all-ones.
- first_err_idx  out  CNT_W  0-based index of the first mismatch.
- first_err_dut  out  DATA_W  DUT data at the first mismatch.
- first_err_gold  out  DATA_W  golden data at the first mismatch.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to RUN.
  - All outputs and counters go to 0, including both readys.
  - The first handshake is possible on the first clk edge after rst deasserts.
- State RUN, join handshake:
  - dut_ready = gold_ready = dut_valid & gold_valid (combinational).
  - A beat is accepted when both valids are high. Neither side is consumed alone.
- Per accepted beat in RUN, with results registered one cycle after the handshake edge:
  - beat_count increments.
  - If dut_data != gold_data:
    - mismatch_count increments, saturating.
    - failed is set.
    - If this is the first mismatch, first_err_idx, first_err_dut and first_err_gold capture the pre-increment beat_count and both data words.
  - If dut_last=1:
    - length_err is set when the pre-increment beat_count != EXPECTED_BEATS-1.
    - State goes to DONE.
  - If dut_last=0 and the pre-increment beat_count == EXPECTED_BEATS-1, the DUT overran the golden length:
    - length_err and failed are set.
    - State goes to DONE.
- Watchdog:
  - An idle counter increments each RUN cycle without an accepted beat and clears on every accepted beat.
  - When it reaches TIMEOUT_CYC (non-zero), timed_out and failed are set and state goes to TOUT.
  - An accepted beat in the same cycle the counter would reach the limit takes priority: no timeout.
- States DONE and TOUT:
  - dut_ready=1 so the core never back-pressures permanently. gold_ready=0.
  - Any DUT beat accepted in DONE sets length_err and failed. Data is not compared and beat_count is frozen.
  - finished=1. Both states are sticky until reset.
- failed equals mismatch_count!=0 | length_err | timed_out, registered.
- A mid-stream reset discards all state. The upstream sources are reset by the same rst in the self-test top.
- Combinational paths exist only from valids to readys. There is no path from data to ready.

Decomposition:
- Package ccsds123b2_selftest_pkg holds:
  - enum checker_state_t {RUN, DONE, TOUT}.
  - The default DATA_W and CNT_W constants.
  - The function sat_inc(count) for saturating increment.
- Sub-module axis_join2: the two-input valid/ready join, reusable by other compare stages.
- All counters and capture registers stay in the top module.

Test Plan:
- Identical streams, EXPECTED_BEATS=8, data 0..7, last on beat 7, both valids always high:
  - finished=1 after 8 accepts, failed=0, beat_count=8, mismatch_count=0.
- Beat 3 golden=0x0000_0000_0000_00AA, DUT=0x...00AB; beat 5 also differs:
  - mismatch_count=2, first_err_idx=3, first_err_dut=0xAB, first_err_gold=0xAA, failed=1.
- Last on beat 5, EXPECTED_BEATS=8:
  - length_err=1, finished=1 after 6 beats. Further DUT beats are accepted with dut_ready=1 and beat_count stays at 6.
- No last after 8 beats, EXPECTED_BEATS=8:
  - length_err=1, DONE after beat index 7. A 9th DUT beat is absorbed and gold_ready stays 0.
- TIMEOUT_CYC=20, gold_valid held low after 2 beats:
  - timed_out=1 exactly 20 cycles after the last accept, failed=1, finished=1.
- Random valid toggling on both sides with a mid-stream rst pulse:
  - Outputs read 0 during reset. A second clean 8-beat run then passes with failed=0.
